// File: rtl/aes_key_expand_ctrl_pkg.sv
// Shared types and constants for the AES key-schedule sequencer and its round-key buffer.
package aes_key_expand_ctrl_pkg;

    localparam int RK_MAX = 15;
    localparam int NK128  = 4;
    localparam int NK256  = 8;
    localparam int NRK128 = 11;
    localparam int NRK256 = 15;

    typedef logic [3:0] rcon_idx_t;
    typedef logic [3:0] rk_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_READY
    } ks_state_e;

    // The lane reports only the low three index bits; a wrap from 7 carries into bit 3
    // so AES-128 can reach Rcon entries 8 and 9 (0x1b, 0x36).
    function automatic rcon_idx_t rcon_advance(input rcon_idx_t cur, input logic [2:0] lane_low);
        logic carry;
        carry = cur[3] | ((cur[2:0] == 3'd7) && (lane_low == 3'd0));
        return {carry, lane_low};
    endfunction

endpackage

// File: rtl/aes_key_expand_ctrl_rk_buf.sv
// Round-key register file: one write port, one registered read port with write-through.
module aes_key_expand_ctrl_rk_buf #(
    parameter int RK_MAX = aes_key_expand_ctrl_pkg::RK_MAX
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  aes_key_expand_ctrl_pkg::rk_idx_t wr_idx,
    input  logic [127:0]                     wr_data,
    input  aes_key_expand_ctrl_pkg::rk_idx_t rd_idx,
    output logic [127:0]                     rd_data
);
    import aes_key_expand_ctrl_pkg::*;

    logic [127:0] mem [RK_MAX];

    // Storage is never cleared; the core gates reads on rk_avail.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_idx) < RK_MAX)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (int'(rd_idx) >= RK_MAX) begin
            rd_data <= '0;
        end else if (wr_en && (wr_idx == rd_idx)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES-128/256 key-schedule sequencer: holds the 8-word window, drives the external
// round-key lane one quartet at a time and collects every round key into a buffer.
module aes_key_expand_ctrl #(
    parameter int RK_MAX = aes_key_expand_ctrl_pkg::RK_MAX
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              key_load,
    input  logic [255:0]                      key_in,
    input  logic                              key_256,
    output logic                              busy,
    output logic                              ready,
    output logic [3:0]                        rk_avail,
    input  logic [3:0]                        rk_rd_idx,
    output logic [127:0]                      rk_rd_data,
    output logic [31:0]                       lane_w0,
    output logic [31:0]                       lane_w1,
    output logic [31:0]                       lane_w2,
    output logic [31:0]                       lane_w3,
    output logic [31:0]                       lane_w4,
    output logic [31:0]                       lane_w5,
    output logic [31:0]                       lane_w6,
    output logic [31:0]                       lane_w7,
    output aes_key_expand_ctrl_pkg::rcon_idx_t lane_rcon_idx,
    output logic                              lane_use_rcon,
    output logic                              lane_start,
    input  logic [31:0]                       lane_w8,
    input  logic [31:0]                       lane_w9,
    input  logic [31:0]                       lane_w10,
    input  logic [31:0]                       lane_w11,
    input  logic [2:0]                        lane_rcon_idx_out,
    input  logic                              lane_use_rcon_out,
    input  logic                              lane_done
);
    import aes_key_expand_ctrl_pkg::*;

    ks_state_e    state_q, state_d;
    logic         mode256_q;
    logic         inflight_q;
    logic [31:0]  win_q [8];
    rcon_idx_t    rcon_q;
    logic         use_rcon_q;
    logic [3:0]   rk_avail_q;
    logic [3:0]   nrk;
    logic         quartet_ok;
    logic         issue_fire;
    logic         wr_en;
    rk_idx_t      wr_idx;
    logic [127:0] wr_data;

    assign nrk = mode256_q ? 4'(NRK256) : 4'(NRK128);

    // After an abort the FSM stalls in ISSUE until the stray done clears inflight,
    // so a done seen in WAIT with inflight set always belongs to the current key.
    assign quartet_ok = lane_done && inflight_q && (state_q == ST_WAIT) && !key_load;
    assign issue_fire = (state_q == ST_ISSUE) && !inflight_q && !key_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        ready   = 1'b0;
        if (key_load) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD:  state_d = ST_ISSUE;
                ST_ISSUE: if (!inflight_q) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (quartet_ok) begin
                        state_d = ((rk_avail_q + 4'd1) == nrk) ? ST_READY : ST_ISSUE;
                    end
                end
                default: ;
            endcase
        end
        case (state_q)
            ST_LOAD, ST_ISSUE, ST_WAIT: busy  = 1'b1;
            ST_READY:                   ready = 1'b1;
            default: ;
        endcase
    end

    // RK0 is taken straight from key_in on the load edge so LOAD only needs the
    // single write port for RK1 in AES-256 mode.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (key_load) begin
            wr_en   = 1'b1;
            wr_idx  = 4'd0;
            wr_data = key_in[255:128];
        end else if ((state_q == ST_LOAD) && mode256_q) begin
            wr_en   = 1'b1;
            wr_idx  = 4'd1;
            wr_data = {win_q[4], win_q[5], win_q[6], win_q[7]};
        end else if (quartet_ok) begin
            wr_en   = 1'b1;
            wr_idx  = rk_avail_q;
            wr_data = {lane_w8, lane_w9, lane_w10, lane_w11};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode256_q  <= 1'b0;
            inflight_q <= 1'b0;
            lane_start <= 1'b0;
            rk_avail_q <= '0;
            rcon_q     <= '0;
            use_rcon_q <= 1'b1;
            for (int i = 0; i < NK256; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            lane_start <= issue_fire;
            if (issue_fire) begin
                inflight_q <= 1'b1;
            end else if (lane_done) begin
                inflight_q <= 1'b0;
            end

            if (key_load) begin
                mode256_q  <= key_256;
                rk_avail_q <= '0;
                rcon_q     <= '0;
                use_rcon_q <= 1'b1;
                for (int i = 0; i < NK128; i++) begin
                    win_q[i] <= key_in[255 - 32*i -: 32];
                end
                if (key_256) begin
                    for (int i = NK128; i < NK256; i++) begin
                        win_q[i] <= key_in[255 - 32*i -: 32];
                    end
                end else begin
                    win_q[4] <= '0;
                    win_q[5] <= '0;
                    win_q[6] <= '0;
                    win_q[7] <= key_in[159:128];
                end
            end else if (state_q == ST_LOAD) begin
                rk_avail_q <= mode256_q ? 4'd2 : 4'd1;
            end else if (quartet_ok) begin
                rk_avail_q <= rk_avail_q + 4'd1;
                rcon_q     <= rcon_advance(rcon_q, lane_rcon_idx_out);
                if (mode256_q) begin
                    for (int i = 0; i < NK128; i++) begin
                        win_q[i] <= win_q[i + NK128];
                    end
                    win_q[4]   <= lane_w8;
                    win_q[5]   <= lane_w9;
                    win_q[6]   <= lane_w10;
                    win_q[7]   <= lane_w11;
                    use_rcon_q <= lane_use_rcon_out;
                end else begin
                    // AES-128 applies RotWord+Rcon on every quartet; the lane's toggle is ignored.
                    win_q[0]   <= lane_w8;
                    win_q[1]   <= lane_w9;
                    win_q[2]   <= lane_w10;
                    win_q[3]   <= lane_w11;
                    win_q[7]   <= lane_w11;
                    use_rcon_q <= 1'b1;
                end
            end
        end
    end

    assign rk_avail      = rk_avail_q;
    assign lane_w0       = win_q[0];
    assign lane_w1       = win_q[1];
    assign lane_w2       = win_q[2];
    assign lane_w3       = win_q[3];
    assign lane_w4       = win_q[4];
    assign lane_w5       = win_q[5];
    assign lane_w6       = win_q[6];
    assign lane_w7       = win_q[7];
    assign lane_rcon_idx = rcon_q;
    assign lane_use_rcon = use_rcon_q;

    aes_key_expand_ctrl_rk_buf #(
        .RK_MAX (RK_MAX)
    ) u_rk_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (rk_rd_idx),
        .rd_data (rk_rd_data)
    );

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed bench for aes_key_expand_ctrl with a behavioural key-expansion lane (9-cycle latency).
module tb_aes_key_expand_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_load;
    logic [255:0] key_in;
    logic         key_256;
    logic         busy, ready;
    logic [3:0]   rk_avail;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic [31:0]  lane_w0, lane_w1, lane_w2, lane_w3, lane_w4, lane_w5, lane_w6, lane_w7;
    logic [3:0]   lane_rcon_idx;
    logic         lane_use_rcon, lane_start;
    logic [31:0]  lane_w8, lane_w9, lane_w10, lane_w11;
    logic [2:0]   lane_rcon_idx_out;
    logic         lane_use_rcon_out, lane_done;

    int n_total = 0;
    int n_bad   = 0;
    int overlap = 0;
    int lane_cnt;

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K128_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K128_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K128_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K256_RK1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] K256_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

    initial forever #5 clk = ~clk;

    aes_key_expand_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .key_load          (key_load),
        .key_in            (key_in),
        .key_256           (key_256),
        .busy              (busy),
        .ready             (ready),
        .rk_avail          (rk_avail),
        .rk_rd_idx         (rk_rd_idx),
        .rk_rd_data        (rk_rd_data),
        .lane_w0           (lane_w0),
        .lane_w1           (lane_w1),
        .lane_w2           (lane_w2),
        .lane_w3           (lane_w3),
        .lane_w4           (lane_w4),
        .lane_w5           (lane_w5),
        .lane_w6           (lane_w6),
        .lane_w7           (lane_w7),
        .lane_rcon_idx     (lane_rcon_idx),
        .lane_use_rcon     (lane_use_rcon),
        .lane_start        (lane_start),
        .lane_w8           (lane_w8),
        .lane_w9           (lane_w9),
        .lane_w10          (lane_w10),
        .lane_w11          (lane_w11),
        .lane_rcon_idx_out (lane_rcon_idx_out),
        .lane_use_rcon_out (lane_use_rcon_out),
        .lane_done         (lane_done)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < int'(idx); i++) r = xtime(r);
        return r;
    endfunction

    // Behavioural lane: captures the window on lane_start, answers 9 cycles later.
    initial begin
        logic [31:0] t, n8, n9, n10, n11;
        logic [2:0]  p_idx;
        logic        p_use;
        lane_done = 1'b0; lane_w8 = '0; lane_w9 = '0; lane_w10 = '0; lane_w11 = '0;
        lane_rcon_idx_out = '0; lane_use_rcon_out = 1'b0; lane_cnt = 0;
        n8 = '0; n9 = '0; n10 = '0; n11 = '0; p_idx = '0; p_use = 1'b0;
        forever begin
            @(negedge clk);
            lane_done = 1'b0;
            if (lane_cnt > 0) begin
                lane_cnt--;
                if (lane_cnt == 0) begin
                    lane_w8 = n8; lane_w9 = n9; lane_w10 = n10; lane_w11 = n11;
                    lane_rcon_idx_out = p_idx; lane_use_rcon_out = p_use;
                    lane_done = 1'b1;
                end
            end
            if (lane_start) begin
                if (lane_cnt != 0) overlap++;
                if (lane_use_rcon)
                    t = subword({lane_w7[23:0], lane_w7[31:24]}) ^ {rcon_of(lane_rcon_idx), 24'h0};
                else
                    t = subword(lane_w7);
                n8  = lane_w0 ^ t;
                n9  = lane_w1 ^ n8;
                n10 = lane_w2 ^ n9;
                n11 = lane_w3 ^ n10;
                p_idx = lane_use_rcon ? 3'(lane_rcon_idx + 4'd1) : lane_rcon_idx[2:0];
                p_use = ~lane_use_rcon;
                lane_cnt = 8;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [255:0] k, input logic is256);
        @(negedge clk);
        key_in = k; key_256 = is256; key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(ready), 128'd1);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!lane_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(lane_start), 128'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!lane_done && n < 50);
        chk(tag, 128'(lane_done), 128'd1);
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] d);
        @(negedge clk);
        rk_rd_idx = idx;
        @(negedge clk);
        d = rk_rd_data;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"},     128'(busy),          128'd0);
        chk({pfx, "_ready"},    128'(ready),         128'd0);
        chk({pfx, "_avail"},    128'(rk_avail),      128'd0);
        chk({pfx, "_rdata"},    rk_rd_data,          128'd0);
        chk({pfx, "_start"},    128'(lane_start),    128'd0);
        chk({pfx, "_w0"},       128'(lane_w0),       128'd0);
        chk({pfx, "_w7"},       128'(lane_w7),       128'd0);
        chk({pfx, "_rcon_idx"}, 128'(lane_rcon_idx), 128'd0);
        chk({pfx, "_use_rcon"}, 128'(lane_use_rcon), 128'd1);
    endtask

    initial begin
        logic [127:0] d;
        rst_n = 1'b0; key_load = 1'b0; key_in = '0; key_256 = 1'b0; rk_rd_idx = 4'd15;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // AES-128, FIPS-197 A.1
        do_load(KEY128, 1'b0);
        chk("a128_busy_after_load", 128'(busy), 128'd1);
        chk("a128_avail_after_load", 128'(rk_avail), 128'd0);
        @(negedge clk);
        chk("a128_avail_load", 128'(rk_avail), 128'd1);
        chk("a128_win_w7", 128'(lane_w7), 128'h09cf4f3c);
        wait_ready("a128_ready");
        chk("a128_busy_done", 128'(busy), 128'd0);
        chk("a128_avail", 128'(rk_avail), 128'd11);
        chk("a128_w5_zero", 128'(lane_w5), 128'd0);
        read_rk(4'd0, d);  chk("a128_rk0", d, KEY128[255:128]);
        read_rk(4'd1, d);  chk("a128_rk1", d, K128_RK1);
        read_rk(4'd2, d);  chk("a128_rk2", d, K128_RK2);
        read_rk(4'd10, d); chk("a128_rk10", d, K128_RK10);
        read_rk(4'd15, d); chk("rd_idx15", d, 128'd0);

        // AES-256, FIPS-197 A.3, with a write-through read on the first quartet
        do_load(KEY256, 1'b1);
        wait_done("a256_first_done");
        chk("wt_idx", 128'(rk_avail), 128'd2);
        rk_rd_idx = rk_avail;
        @(negedge clk); #1;
        chk("wt_data", rk_rd_data, K256_RK2);
        wait_ready("a256_ready");
        chk("a256_avail", 128'(rk_avail), 128'd15);
        chk("a256_busy_done", 128'(busy), 128'd0);
        read_rk(4'd1, d);  chk("a256_rk1", d, K256_RK1);
        read_rk(4'd2, d);  chk("a256_rk2", d, K256_RK2);
        read_rk(4'd14, d); chk("a256_rk14", d, K256_RK14);

        // Abort an AES-256 expansion while the lane is busy, restart with the AES-128 key
        do_load(KEY256, 1'b1);
        wait_start("abort_first_start");
        repeat (3) @(negedge clk);
        do_load(KEY128, 1'b0);
        chk("abort_avail", 128'(rk_avail), 128'd0);
        chk("abort_ready", 128'(ready), 128'd0);
        chk("abort_busy", 128'(busy), 128'd1);
        wait_done("abort_stray_done");
        chk("abort_stray_avail", 128'(rk_avail), 128'd1);
        @(negedge clk); #1;
        chk("abort_stray_nowrite", 128'(rk_avail), 128'd1);
        chk("abort_win_w0", 128'(lane_w0), 128'h2b7e1516);
        wait_ready("abort_ready_final");
        chk("abort_avail_final", 128'(rk_avail), 128'd11);
        chk("abort_w4_zero", 128'(lane_w4), 128'd0);
        read_rk(4'd1, d);  chk("abort_rk1", d, K128_RK1);
        read_rk(4'd10, d); chk("abort_rk10", d, K128_RK10);

        // Reset asserted while waiting on the lane
        do_load(KEY128, 1'b0);
        wait_start("rstw_start");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("rstw");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        do_load(KEY256, 1'b1);
        wait_ready("rstw_ready");
        chk("rstw_avail", 128'(rk_avail), 128'd15);
        read_rk(4'd14, d); chk("rstw_rk14", d, K256_RK14);

        chk("lane_overlap", 128'(overlap), 128'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
